// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//   BCD stopwatch / countdown timer controller (MM:SS.CC).
//   Owns the run/pause/lap/expire state machine, the centisecond prescaler
//   (TICK_DIV ms ticks per centisecond) and the BCD time datapath.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : LAP state, lap latch and lap_active are present.
//   undefined : btn_lap ignored, lap_active tied 0, display always live.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   ms_tick    in   1-cycle pulse every 1 ms
//   btn_ss     in   start/stop pulse
//   btn_clr    in   clear pulse
//   btn_lap    in   lap / resume-display pulse
//   mode       in   0 = count up, 1 = count down (sampled only in IDLE)
//   disp_min   out  BCD minutes shown
//   disp_sec   out  BCD seconds shown
//   disp_cs    out  BCD centiseconds shown
//   running    out  high in RUN and LAP
//   lap_active out  high in LAP
//   expired    out  1-cycle pulse when the countdown reaches 00:00.00
//   overflow   out  1-cycle pulse on up-count wrap 59:59.99 -> 00:00.00
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int         TICK_DIV   = 10,
    parameter logic [7:0] PRESET_MIN = 8'h01,
    parameter logic [7:0] PRESET_SEC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms_tick,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    input  logic       mode,
    output logic [7:0] disp_min,
    output logic [7:0] disp_sec,
    output logic [7:0] disp_cs,
    output logic       running,
    output logic       lap_active,
    output logic       expired,
    output logic       overflow
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_PAUSE = 3'd2,
        ST_LAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    // Two-digit BCD increment; bit 8 is the carry out of the field.
    function automatic logic [8:0] bcd2_inc(input logic [7:0] v, input logic [3:0] tens_max);
        logic [8:0] r;
        if (v[3:0] != 4'd9) begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end else if (v[7:4] != tens_max) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b1, 8'h00};
        end
        return r;
    endfunction

    // Two-digit BCD decrement; bit 8 is the borrow out of the field.
    function automatic logic [8:0] bcd2_dec(input logic [7:0] v, input logic [3:0] tens_max);
        logic [8:0] r;
        if (v[3:0] != 4'd0) begin
            r = {1'b0, v[7:4], v[3:0] - 4'd1};
        end else if (v[7:4] != 4'd0) begin
            r = {1'b0, v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {1'b1, tens_max, 4'd9};
        end
        return r;
    endfunction

    // {min,sec,cs} + 1 centisecond; bit 24 flags the 59:59.99 wrap.
    function automatic logic [24:0] cnt_up(input logic [23:0] c);
        logic [8:0]  cs_v;
        logic [8:0]  sec_v;
        logic [8:0]  min_v;
        logic [23:0] r;
        cs_v     = bcd2_inc(c[7:0], 4'd9);
        sec_v    = bcd2_inc(c[15:8], 4'd5);
        min_v    = bcd2_inc(c[23:16], 4'd5);
        r[7:0]   = cs_v[7:0];
        r[15:8]  = cs_v[8] ? sec_v[7:0] : c[15:8];
        r[23:16] = (cs_v[8] && sec_v[8]) ? min_v[7:0] : c[23:16];
        return {cs_v[8] & sec_v[8] & min_v[8], r};
    endfunction

    // {min,sec,cs} - 1 centisecond, saturating at zero; bit 24 flags expiry.
    function automatic logic [24:0] cnt_down(input logic [23:0] c);
        logic [8:0]  cs_v;
        logic [8:0]  sec_v;
        logic [8:0]  min_v;
        logic [23:0] r;
        logic        was_zero;
        was_zero = (c == 24'h000000);
        cs_v     = bcd2_dec(c[7:0], 4'd9);
        sec_v    = bcd2_dec(c[15:8], 4'd5);
        min_v    = bcd2_dec(c[23:16], 4'd5);
        r[7:0]   = cs_v[7:0];
        r[15:8]  = cs_v[8] ? sec_v[7:0] : c[15:8];
        r[23:16] = (cs_v[8] && sec_v[8]) ? min_v[7:0] : c[23:16];
        return {was_zero | (r == 24'h000000), was_zero ? 24'h000000 : r};
    endfunction

    // Counter value loaded on clear / mode change.
    function automatic logic [23:0] preset_val(input logic m);
        return m ? {PRESET_MIN, PRESET_SEC, 8'h00} : 24'h000000;
    endfunction

    state_t      state_r;
    state_t      state_n;
    logic        mode_q_r;
    logic        mode_q_n;
    logic [7:0]  presc_r;
    logic [7:0]  presc_n;
    logic [23:0] cnt_r;
    logic [23:0] cnt_n;
    logic [24:0] up_s;
    logic [24:0] dn_s;
    logic [23:0] cnt_step_s;
    logic        step_s;
    logic        expire_s;
    logic        ovf_s;
    logic [23:0] disp_n;
    logic [23:0] disp_r;
    logic        running_r;
    logic        expired_r;
    logic        overflow_r;
`ifdef STOPWATCH_LAP_EN
    logic [23:0] lap_r;
    logic [23:0] lap_n;
    logic        lap_active_r;
`endif

    // Next-state, prescaler and BCD datapath; the step is resolved before buttons.
    always_comb begin
        state_n    = state_r;
        mode_q_n   = mode_q_r;
        presc_n    = presc_r;
        cnt_n      = cnt_r;
        step_s     = 1'b0;
        expire_s   = 1'b0;
        ovf_s      = 1'b0;
        cnt_step_s = cnt_r;
        up_s       = cnt_up(cnt_r);
        dn_s       = cnt_down(cnt_r);
`ifdef STOPWATCH_LAP_EN
        lap_n      = lap_r;
`endif

        if (state_r == ST_IDLE) begin
            mode_q_n = mode;
        end else begin
            mode_q_n = mode_q_r;
        end

        if (((state_r == ST_RUN) || (state_r == ST_LAP)) && ms_tick) begin
            if (presc_r == TICK_LAST) begin
                presc_n = 8'd0;
                step_s  = 1'b1;
            end else begin
                presc_n = presc_r + 8'd1;
                step_s  = 1'b0;
            end
        end else begin
            presc_n = presc_r;
            step_s  = 1'b0;
        end

        if (mode_q_r) begin
            cnt_step_s = dn_s[23:0];
            expire_s   = step_s & dn_s[24];
        end else begin
            cnt_step_s = up_s[23:0];
            ovf_s      = step_s & up_s[24];
        end

        // IDLE and stepping are exclusive, so the mode re-preset never races a step.
        if ((state_r == ST_IDLE) && (mode != mode_q_r)) begin
            cnt_n = preset_val(mode);
        end else if (step_s) begin
            cnt_n = cnt_step_s;
        end else begin
            cnt_n = cnt_r;
        end

        if (btn_clr) begin
            state_n  = ST_IDLE;
            presc_n  = 8'd0;
            cnt_n    = preset_val(mode_q_n);
            expire_s = 1'b0;
            ovf_s    = 1'b0;
`ifdef STOPWATCH_LAP_EN
            lap_n    = 24'h000000;
`endif
        end else if (expire_s) begin
            state_n = ST_DONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (btn_ss && !(mode_q_r && (cnt_r == 24'h000000))) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (btn_ss) begin
                        state_n = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                    end else if (btn_lap) begin
                        state_n = ST_LAP;
                        lap_n   = cnt_n;
`endif
                    end else begin
                        state_n = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (btn_ss) begin
                        state_n = ST_RUN;
                    end else begin
                        state_n = ST_PAUSE;
                    end
                end
                ST_LAP: begin
                    if (btn_ss) begin
                        state_n = ST_PAUSE;
`ifdef STOPWATCH_LAP_EN
                    end else if (btn_lap) begin
                        state_n = ST_RUN;
`endif
                    end else begin
                        state_n = ST_LAP;
                    end
                end
                ST_DONE: begin
                    state_n = ST_DONE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

`ifdef STOPWATCH_LAP_EN
        if (state_n == ST_LAP) begin
            disp_n = lap_n;
        end else begin
            disp_n = cnt_n;
        end
`else
        disp_n = cnt_n;
`endif
    end

    // Control state, sampled mode, prescaler and live counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mode_q_r <= 1'b0;
            presc_r  <= 8'd0;
            cnt_r    <= 24'h000000;
        end else begin
            state_r  <= state_n;
            mode_q_r <= mode_q_n;
            presc_r  <= presc_n;
            cnt_r    <= cnt_n;
        end
    end

    // Registered outputs, loaded from the post-update values so every output
    // reflects the same cycle's step and transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_r     <= 24'h000000;
            running_r  <= 1'b0;
            expired_r  <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            disp_r     <= disp_n;
            running_r  <= (state_n == ST_RUN) || (state_n == ST_LAP);
            expired_r  <= expire_s;
            overflow_r <= ovf_s;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap latch and lap indicator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_r        <= 24'h000000;
            lap_active_r <= 1'b0;
        end else begin
            lap_r        <= lap_n;
            lap_active_r <= (state_n == ST_LAP);
        end
    end

    assign lap_active = lap_active_r;
`else
    assign lap_active = 1'b0;
`endif

    assign disp_min = disp_r[23:16];
    assign disp_sec = disp_r[15:8];
    assign disp_cs  = disp_r[7:0];
    assign running  = running_r;
    assign expired  = expired_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Self-checking bench for stopwatch_ctrl (TICK_DIV=10, preset 01:00.00).
//   The reference model keeps time as an integer number of centiseconds and
//   converts to BCD with division; every cycle's outputs are compared to it.
//   Lap sequences run only when STOPWATCH_LAP_EN is defined.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int TICK_DIV = 10;
    localparam int PRESET_T = 6000;      // 01:00.00 in centiseconds
    localparam int WRAP_T   = 360000;    // 60:00.00 in centiseconds
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;
    localparam int S_DONE  = 4;

    logic       clk;
    logic       rst;
    logic       ms_tick;
    logic       btn_ss;
    logic       btn_clr;
    logic       btn_lap;
    logic       mode;
    logic [7:0] disp_min;
    logic [7:0] disp_sec;
    logic [7:0] disp_cs;
    logic       running;
    logic       lap_active;
    logic       expired;
    logic       overflow;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .PRESET_MIN(8'h01),
        .PRESET_SEC(8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ms_tick   (ms_tick),
        .btn_ss    (btn_ss),
        .btn_clr   (btn_clr),
        .btn_lap   (btn_lap),
        .mode      (mode),
        .disp_min  (disp_min),
        .disp_sec  (disp_sec),
        .disp_cs   (disp_cs),
        .running   (running),
        .lap_active(lap_active),
        .expired   (expired),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_state;
    int m_t;
    int m_lap;
    int m_presc;
    bit m_modeq;
    logic [23:0] e_disp;
    bit e_run;
    bit e_lapact;
    bit e_exp;
    bit e_ovf;
    bit md_hold;

    typedef struct {
        bit clr;
        bit ss;
        bit lp;
        bit tick;
        bit md;
        logic [23:0] disp;
        bit run;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] to_bcd(input int t);
        int mn;
        int sc;
        int c;
        mn = t / 6000;
        sc = (t / 100) % 60;
        c  = t % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE;
        m_t = 0;
        m_lap = 0;
        m_presc = 0;
        m_modeq = 1'b0;
        e_disp = 24'h0;
        e_run = 1'b0;
        e_lapact = 1'b0;
        e_exp = 1'b0;
        e_ovf = 1'b0;
    endtask

    task automatic model_cycle(input bit clr, input bit ss, input bit lp, input bit tick, input bit md);
        int nt;
        int ns;
        int np;
        int nlap;
        bit nmq;
        bit stp;
        bit ovf;
        bit exd;
        nt = m_t; ns = m_state; np = m_presc; nlap = m_lap;
        stp = 1'b0; ovf = 1'b0; exd = 1'b0;
        nmq = (m_state == S_IDLE) ? md : m_modeq;
        if ((m_state == S_RUN || m_state == S_LAP) && tick) begin
            np = m_presc + 1;
            if (np == TICK_DIV) begin
                np = 0;
                stp = 1'b1;
            end
        end
        if (stp) begin
            if (m_modeq) begin
                nt = (m_t > 0) ? m_t - 1 : 0;
                exd = (nt == 0);
            end else begin
                nt = (m_t + 1) % WRAP_T;
                ovf = (nt == 0);
            end
        end
        if (m_state == S_IDLE && md != m_modeq) nt = md ? PRESET_T : 0;
        if (clr) begin
            ns = S_IDLE; np = 0; nlap = 0;
            nt = nmq ? PRESET_T : 0;
            ovf = 1'b0; exd = 1'b0;
        end else if (exd) begin
            ns = S_DONE;
        end else begin
            case (m_state)
                S_IDLE:  if (ss && !(m_modeq && m_t == 0)) ns = S_RUN;
                S_RUN:   if (ss) ns = S_PAUSE;
                         else if (lp && LAP_ON) begin ns = S_LAP; nlap = nt; end
                S_PAUSE: if (ss) ns = S_RUN;
                S_LAP:   if (ss) ns = S_PAUSE;
                         else if (lp) ns = S_RUN;
                default: ns = m_state;
            endcase
        end
        m_state = ns; m_t = nt; m_lap = nlap; m_presc = np; m_modeq = nmq;
        e_disp   = to_bcd((ns == S_LAP) ? nlap : nt);
        e_run    = (ns == S_RUN) || (ns == S_LAP);
        e_lapact = (ns == S_LAP);
        e_exp    = exd;
        e_ovf    = ovf;
    endtask

    // One clock: drive at edge+1, model, then compare all outputs at next edge+1.
    task automatic step_cycle(input bit clr, input bit ss, input bit lp, input bit tick, input string name);
        btn_clr = clr; btn_ss = ss; btn_lap = lp; ms_tick = tick; mode = md_hold;
        model_cycle(clr, ss, lp, tick, md_hold);
        @(posedge clk);
        #1;
        check(name, {4'd0, disp_min, disp_sec, disp_cs, running, lap_active, expired, overflow},
              {4'd0, e_disp, e_run, e_lapact, e_exp, e_ovf});
        btn_clr = 1'b0; btn_ss = 1'b0; btn_lap = 1'b0; ms_tick = 1'b0;
    endtask

    task automatic ticks(input int n, input string name);
        for (int i = 0; i < n; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b1, name);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async", {4'd0, disp_min, disp_sec, disp_cs, running, lap_active, expired, overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic add(input bit clr, input bit ss, input bit lp, input bit tick, input bit md,
                       input logic [23:0] disp, input bit run);
        vec_t v;
        v.clr = clr; v.ss = ss; v.lp = lp; v.tick = tick; v.md = md; v.disp = disp; v.run = run;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b0; ms_tick = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        mode = 1'b0; md_hold = 1'b0;

        // directed vector table, applied from reset
        add(0, 0, 0, 0, 0, 24'h000000, 0);
        add(0, 1, 0, 0, 0, 24'h000000, 1);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 1, 0, 24'h000000, 1);
        add(0, 0, 0, 1, 0, 24'h000001, 1);
        add(0, 1, 0, 1, 0, 24'h000001, 0);
        add(0, 0, 0, 1, 0, 24'h000001, 0);
        add(0, 0, 0, 1, 0, 24'h000001, 0);
        add(0, 1, 0, 0, 0, 24'h000001, 1);
        for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 0, 24'h000001, 1);
        add(0, 1, 0, 1, 0, 24'h000002, 0);
        add(1, 1, 1, 0, 0, 24'h000000, 0);
        add(0, 0, 0, 0, 1, 24'h010000, 0);
        add(1, 0, 0, 0, 1, 24'h010000, 0);
        add(0, 0, 0, 0, 0, 24'h000000, 0);
        add(0, 1, 0, 0, 0, 24'h000000, 1);

        #2;
        do_reset();

        foreach (tbl[k]) begin
            md_hold = tbl[k].md;
            step_cycle(tbl[k].clr, tbl[k].ss, tbl[k].lp, tbl[k].tick, "tbl_model");
            check("tbl_disp", {8'd0, disp_min, disp_sec, disp_cs}, {8'd0, tbl[k].disp});
            check("tbl_running", {31'd0, running}, {31'd0, tbl[k].run});
        end

        // 1000 ticks from reset -> 00:01.00, then pause holds
        md_hold = 1'b0;
        do_reset();
        step_cycle(0, 1, 0, 0, "s1_start");
        ticks(1000, "s1_count");
        check("s1_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00000100);
        check("s1_running", {31'd0, running}, 32'd1);
        step_cycle(0, 1, 0, 0, "s1_pause");
        ticks(5, "s1_paused_ticks");
        check("s1_pause_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00000100);
        check("s1_pause_run", {31'd0, running}, 32'd0);

        // 59:59.99 wrap
        force dut.cnt_r = 24'h595999;
        m_t = 359999;
        step_cycle(0, 0, 0, 0, "s2_force");
        release dut.cnt_r;
        step_cycle(0, 0, 0, 0, "s2_hold");
        step_cycle(0, 1, 0, 0, "s2_resume");
        ticks(9, "s2_pre");
        step_cycle(0, 0, 0, 1, "s2_wrap");
        check("s2_wrap_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'd0);
        check("s2_ovf_high", {31'd0, overflow}, 32'd1);
        check("s2_run_kept", {31'd0, running}, 32'd1);
        step_cycle(0, 0, 0, 1, "s2_after");
        check("s2_ovf_low", {31'd0, overflow}, 32'd0);

        // countdown to expiry
        md_hold = 1'b1;
        step_cycle(1, 0, 0, 0, "s3_clr_run");
        step_cycle(0, 0, 0, 0, "s3_mode");
        step_cycle(1, 0, 0, 0, "s3_clr");
        check("s3_preset", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00010000);
        step_cycle(0, 1, 0, 0, "s3_start");
        ticks(1000, "s3_down");
        check("s3_borrow", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00005900);
        step_cycle(0, 1, 0, 0, "s3_pause");
        force dut.cnt_r = 24'h000005;
        m_t = 5;
        step_cycle(0, 0, 0, 0, "s3_force");
        release dut.cnt_r;
        step_cycle(0, 1, 0, 0, "s3_resume");
        ticks(49, "s3_down2");
        step_cycle(0, 0, 0, 1, "s3_expire");
        check("s3_exp_high", {31'd0, expired}, 32'd1);
        check("s3_exp_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'd0);
        check("s3_exp_run", {31'd0, running}, 32'd0);
        step_cycle(0, 0, 0, 1, "s3_done");
        check("s3_exp_low", {31'd0, expired}, 32'd0);
        step_cycle(0, 1, 0, 1, "s3_ss_ignored");
        check("s3_done_stays", {31'd0, running}, 32'd0);
        step_cycle(1, 0, 0, 0, "s3_clr_done");
        check("s3_clr_preset", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00010000);

`ifdef STOPWATCH_LAP_EN
        // lap freeze and release
        md_hold = 1'b0;
        step_cycle(0, 0, 0, 0, "s4_mode");
        step_cycle(1, 0, 0, 0, "s4_clr");
        step_cycle(0, 1, 0, 0, "s4_start");
        ticks(500, "s4_run");
        step_cycle(0, 0, 1, 0, "s4_lap");
        check("s4_lap_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00000050);
        check("s4_lap_active", {31'd0, lap_active}, 32'd1);
        ticks(2000, "s4_frozen");
        check("s4_frozen_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00000050);
        step_cycle(0, 0, 1, 0, "s4_unlap");
        check("s4_live_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00000250);
        check("s4_lap_off", {31'd0, lap_active}, 32'd0);
`endif

        // clear wins over start and a completing tick; prescaler survives pause
        md_hold = 1'b0;
        step_cycle(0, 0, 0, 0, "s5_mode");
        step_cycle(1, 0, 0, 0, "s5_clr");
        step_cycle(0, 1, 0, 0, "s5_start");
        ticks(9, "s5_pre");
        step_cycle(1, 1, 0, 1, "s5_clr_combo");
        check("s5_combo_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'd0);
        check("s5_combo_run", {31'd0, running}, 32'd0);
        step_cycle(0, 1, 0, 0, "s5_start2");
        ticks(7, "s5_seven");
        step_cycle(0, 1, 0, 0, "s5_pause");
        step_cycle(0, 1, 0, 0, "s5_resume");
        ticks(2, "s5_two");
        check("s5_no_step", {8'd0, disp_min, disp_sec, disp_cs}, 32'd0);
        ticks(1, "s5_third");
        check("s5_one_step", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00000001);

        // asynchronous reset mid-count
        step_cycle(1, 0, 0, 0, "s6_clr");
        step_cycle(0, 1, 0, 0, "s6_start");
        ticks(12340, "s6_count");
        check("s6_disp", {8'd0, disp_min, disp_sec, disp_cs}, 32'h00001234);
        do_reset();
        ticks(20, "s6_after_rst");

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bit c, s, l, t;
            c = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 8);
            l = ($urandom_range(0, 99) < 6);
            t = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 5) md_hold = ~md_hold;
            step_cycle(c, s, l, t, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
